// File: rtl/tr_pkg.sv
// tr_pkg: state encoding and default parameters shared by the step/ramp controller.
package tr_pkg;
  localparam int DEF_SIZE = 16;
  localparam int DEF_START_PERIOD = 2000;
  localparam int DEF_ACCEL_STEP = 50;
  localparam int DEF_DIR_SETUP = 4;
  localparam int MIN_PERIOD = 4;
  typedef enum logic [2:0] {IDLE, SETUP, ACCEL, CRUISE, DECEL, FINISH} state_t;
endpackage

// File: rtl/step_timer.sv
// step_timer: times one step period, high for max(1, period/4) cycles, strobes the last cycle.
module step_timer
  import tr_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [SIZE-1:0] period,
  output logic            step,
  output logic            period_end
);
  localparam logic [SIZE-1:0] ONE = SIZE'(1);
  logic [SIZE-1:0] cnt, high;
  assign high = (period >> 2) == '0 ? ONE : period >> 2;
  assign period_end = run && cnt == period - ONE;
  assign step = run && cnt < high;
  always_ff @(posedge clk) begin
    if (rst || !run || period_end) cnt <= '0;
    else cnt <= cnt + ONE;
  end
endmodule

// File: rtl/step_ramp_ctrl.sv
// step_ramp_ctrl: trapezoidal step/dir motion controller with controlled stop and emergency stop.
module step_ramp_ctrl
  import tr_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int START_PERIOD = DEF_START_PERIOD,
  parameter int ACCEL_STEP = DEF_ACCEL_STEP,
  parameter int DIR_SETUP = DEF_DIR_SETUP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_dir,
  input  logic [SIZE-1:0] cmd_steps,
  input  logic [SIZE-1:0] cmd_period,
  input  logic            stop,
  input  logic            estop,
  output logic            step,
  output logic            dir,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [SIZE-1:0] steps_done
);
  localparam logic [SIZE-1:0] ONE = SIZE'(1);
  localparam logic [SIZE-1:0] SP = SIZE'(START_PERIOD);
  localparam logic [SIZE-1:0] AS = SIZE'(ACCEL_STEP);
  localparam logic [SIZE-1:0] MINP = SIZE'(MIN_PERIOD);
  localparam logic [SIZE-1:0] DS_LAST = SIZE'(DIR_SETUP - 1);
  state_t state, state_n;
  logic [SIZE-1:0] steps_r, steps_n, target, target_n, cur_period, cur_n;
  logic [SIZE-1:0] sd_n, ramp_steps, ramp_n, setup_cnt, setup_n;
  logic [SIZE-1:0] eff_steps, sd_inc, clamped, acc_p, dec_p;
  logic dir_n, aborted_n, accept, stop_ramp, run, t_step, period_end;
  assign run = state inside {ACCEL, CRUISE, DECEL};
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign step = t_step && !estop;
  step_timer #(.SIZE(SIZE)) u_timer (
    .clk(clk),
    .rst(rst),
    .run(run),
    .period(cur_period),
    .step(t_step),
    .period_end(period_end)
  );
  always_comb begin
    accept = cmd_valid && cmd_ready;
    clamped = cmd_period < MINP ? MINP : (cmd_period > SP ? SP : cmd_period);
    stop_ramp = stop && !estop && (state == ACCEL || state == CRUISE);
    // a stop lets the current step finish, then mirrors the ramp taken so far
    eff_steps = stop_ramp ? steps_done + ramp_steps + ONE : steps_r;
    sd_inc = steps_done + ONE;
    acc_p = (cur_period - target) > AS ? cur_period - AS : target;
    dec_p = (SP - cur_period) > AS ? cur_period + AS : SP;
    state_n = state;
    steps_n = eff_steps;
    target_n = target;
    cur_n = cur_period;
    sd_n = steps_done;
    ramp_n = ramp_steps;
    setup_n = setup_cnt;
    dir_n = dir;
    aborted_n = aborted;
    if (accept) begin
      dir_n = cmd_dir;
      steps_n = cmd_steps;
      target_n = clamped;
      cur_n = SP;
      sd_n = '0;
      ramp_n = '0;
      setup_n = '0;
      aborted_n = 1'b0;
      state_n = cmd_steps == '0 ? FINISH : SETUP;
    end else if (estop && state != IDLE && state != FINISH) begin
      state_n = FINISH;
      aborted_n = 1'b1;
    end else if (state == SETUP) begin
      if (stop) state_n = FINISH;
      else if (setup_cnt == DS_LAST) state_n = target == SP ? CRUISE : ACCEL;
      else setup_n = setup_cnt + ONE;
    end else if (state == FINISH) begin
      state_n = IDLE;
    end else if (run && period_end) begin
      sd_n = sd_inc;
      if (state == ACCEL) begin
        ramp_n = ramp_steps + ONE;
        cur_n = acc_p;
        if (acc_p == target) state_n = CRUISE;
      end
      if (sd_inc == eff_steps) state_n = FINISH;
      else if (state == DECEL || eff_steps - sd_inc <= ramp_n) begin
        state_n = DECEL;
        cur_n = dec_p;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      steps_r <= '0;
      target <= '0;
      cur_period <= '0;
      steps_done <= '0;
      ramp_steps <= '0;
      setup_cnt <= '0;
      dir <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state <= state_n;
      steps_r <= steps_n;
      target <= target_n;
      cur_period <= cur_n;
      steps_done <= sd_n;
      ramp_steps <= ramp_n;
      setup_cnt <= setup_n;
      dir <= dir_n;
      aborted <= aborted_n;
    end
  end
endmodule

// File: tb/tb_step_ramp_ctrl.sv
// tb_step_ramp_ctrl: randomized and directed moves checked against a motion-profile model.
module tb_step_ramp_ctrl;
  localparam int SIZE = 16;
  localparam int SP = 200;
  localparam int AS = 10;
  localparam int DS = 4;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_dir = 0, stop = 0, estop = 0;
  logic [SIZE-1:0] cmd_steps = '0, cmd_period = '0;
  logic cmd_ready, step, dir, busy, done, aborted, exp_dir, busy_after;
  logic [SIZE-1:0] steps_done;
  int checks = 0, errors = 0;
  int exp_q[$], rise_q[$], high_q[$];
  int done_at, done_n, dir_bad, ready_busy;

  always #5 clk = ~clk;

  step_ramp_ctrl #(.SIZE(SIZE), .START_PERIOD(SP), .ACCEL_STEP(AS), .DIR_SETUP(DS)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .stop(stop), .estop(estop), .step(step),
    .dir(dir), .busy(busy), .done(done), .aborted(aborted), .steps_done(steps_done)
  );

  function automatic int clampp(int p);
    return p < 4 ? 4 : (p > SP ? SP : p);
  endfunction

  function automatic int ramp_len(int per);
    return (SP - clampp(per) + AS - 1) / AS;
  endfunction

  // accel up to ceil(n/2) steps, decel up to floor(n/2), cruise whatever is left
  function automatic void build_model(int n, int per);
    int t = clampp(per);
    int r = ramp_len(per);
    int a = r < (n + 1) / 2 ? r : (n + 1) / 2;
    int d = r < n / 2 ? r : n / 2;
    int c = n - a - d;
    int base = c > 0 ? t : (a > 0 ? SP - (a - 1) * AS : SP);
    exp_q.delete();
    for (int j = 0; j < a; j++) exp_q.push_back(SP - j * AS);
    for (int j = 0; j < c; j++) exp_q.push_back(t);
    for (int j = 1; j <= d; j++) exp_q.push_back(base + j * AS > SP ? SP : base + j * AS);
  endfunction

  function automatic int model_sum();
    int s = 0;
    foreach (exp_q[k]) s += exp_q[k];
    return s;
  endfunction

  task automatic send_cmd(input logic d, input int n, input int per);
    cmd_valid = 1;
    cmd_dir = d;
    cmd_steps = SIZE'(n);
    cmd_period = SIZE'(per);
    exp_dir = d;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic collect(input int budget, input int stop_rise, input bit junk);
    logic prev = 0;
    rise_q.delete();
    high_q.delete();
    done_at = -1;
    done_n = 0;
    dir_bad = 0;
    ready_busy = 0;
    busy_after = 1'bx;
    for (int c = 0; c < budget; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      stop = 0;
      cmd_valid = 0;
      if (step && !prev) begin
        rise_q.push_back(c);
        high_q.push_back(0);
        stop = rise_q.size() == stop_rise;
      end
      if (step) high_q[high_q.size() - 1]++;
      prev = step;
      if (busy && dir !== exp_dir) dir_bad++;
      if (busy && cmd_ready) ready_busy++;
      if (done) done_n++;
      if (done && done_at < 0) done_at = c;
      if (junk && busy && c >= 1 && c <= 8) begin
        cmd_valid = 1;
        cmd_dir = !exp_dir;
        cmd_steps = SIZE'(7);
        cmd_period = SIZE'(50);
      end
      if (done_at >= 0 && c == done_at + 1) begin
        busy_after = busy;
        break;
      end
    end
    cmd_valid = 0;
    stop = 0;
    checks++;
    if (done_at < 0) begin
      errors++;
      $display("FAIL timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({step, dir, busy, done, aborted, cmd_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000001", {step, dir, busy, done, aborted, cmd_ready});
    end
    checks++;
    if (steps_done !== '0) begin
      errors++;
      $display("FAIL reset_steps_done: got %0d expected 0", steps_done);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_profiles;
    int tn[6] = '{10, 100, 6, 0, 42, 5};
    int tp[6] = '{200, 100, 10, 50, 1, 300};
    for (int i = 0; i < 11; i++) begin
      int n = i < 6 ? tn[i] : int'($urandom_range(0, 20));
      int per = i < 6 ? tp[i] : int'($urandom_range(0, 260));
      logic d = 1'($urandom_range(0, 1));
      int exp_done;
      build_model(n, per);
      exp_done = n == 0 ? 0 : DS + model_sum();
      send_cmd(d, n, per);
      collect(exp_done + 50, 0, 0);
      checks++;
      if (done_at !== exp_done) begin
        errors++;
        $display("FAIL done_cycle n=%0d per=%0d: got %0d expected %0d", n, per, done_at, exp_done);
      end
      checks++;
      if (done_n !== 1) begin
        errors++;
        $display("FAIL done_pulses n=%0d: got %0d expected 1", n, done_n);
      end
      checks++;
      if (rise_q.size() !== n) begin
        errors++;
        $display("FAIL pulse_count n=%0d per=%0d: got %0d expected %0d", n, per, rise_q.size(), n);
      end else begin
        for (int k = 0; k < n; k++) begin
          int pm = (k == n - 1 ? done_at : rise_q[k + 1]) - rise_q[k];
          int hw = exp_q[k] >> 2;
          if (hw == 0) hw = 1;
          checks++;
          if (pm !== exp_q[k]) begin
            errors++;
            $display("FAIL period n=%0d step=%0d: got %0d expected %0d", n, k + 1, pm, exp_q[k]);
          end
          checks++;
          if (high_q[k] !== hw) begin
            errors++;
            $display("FAIL high_width n=%0d step=%0d: got %0d expected %0d", n, k + 1, high_q[k], hw);
          end
        end
      end
      checks++;
      if (steps_done !== SIZE'(n) || aborted !== 1'b0 || busy_after !== 1'b0 || dir_bad !== 0) begin
        errors++;
        $display("FAIL move_end n=%0d: steps_done=%0d aborted=%b busy=%b dir_bad=%0d expected %0d,0,0,0",
                 n, steps_done, aborted, busy_after, dir_bad, n);
      end
    end
  endtask

  task automatic test_stop;
    int sn[2] = '{40, 40};
    int sp[2] = '{100, 100};
    int ss[2] = '{15, 4};
    for (int i = 0; i < 2; i++) begin
      int r = ramp_len(sp[i]);
      int n2 = ss[i] + (ss[i] - 1 < r ? ss[i] - 1 : r);
      int exp_done;
      build_model(n2, sp[i]);
      exp_done = DS + model_sum();
      send_cmd(1, sn[i], sp[i]);
      collect(DS + 8000, ss[i], 0);
      checks++;
      if (rise_q.size() !== n2 || steps_done !== SIZE'(n2)) begin
        errors++;
        $display("FAIL stop_count s=%0d: pulses=%0d steps_done=%0d expected %0d", ss[i], rise_q.size(), steps_done, n2);
      end
      checks++;
      if (done_at !== exp_done) begin
        errors++;
        $display("FAIL stop_done_cycle s=%0d: got %0d expected %0d", ss[i], done_at, exp_done);
      end
      for (int k = 0; k + 1 < rise_q.size() && k + 1 < n2; k++) begin
        checks++;
        if (rise_q[k + 1] - rise_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL stop_period s=%0d step=%0d: got %0d expected %0d", ss[i], k + 1, rise_q[k + 1] - rise_q[k], exp_q[k]);
        end
      end
    end
    send_cmd(0, 5, 100);
    stop = 1;
    @(posedge clk); #1;
    stop = 0;
    checks++;
    if (done !== 1'b1 || steps_done !== '0 || step !== 1'b0) begin
      errors++;
      $display("FAIL stop_setup: done=%b steps_done=%0d step=%b expected 1,0,0", done, steps_done, step);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_setup_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_estop;
    int r = 0, c = 0;
    logic p = 0;
    send_cmd(1, 20, 100);
    while (r < 5 && c < 5000) begin
      @(posedge clk); #1;
      c++;
      if (step && !p) r++;
      p = step;
    end
    checks++;
    if (r < 5) begin
      errors++;
      $display("FAIL estop_wait: saw %0d pulses expected 5", r);
    end
    estop = 1;
    #1;
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL estop_gate: step=%b expected 0", step);
    end
    @(posedge clk); #1;
    estop = 0;
    checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || steps_done !== SIZE'(4) || step !== 1'b0) begin
      errors++;
      $display("FAIL estop_finish: done=%b aborted=%b steps_done=%0d step=%b expected 1,1,4,0", done, aborted, steps_done, step);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL estop_idle: busy=%b aborted=%b done=%b expected 0,1,0", busy, aborted, done);
    end
    send_cmd(0, 0, 50);
    checks++;
    if (aborted !== 1'b0 || done !== 1'b1 || steps_done !== '0) begin
      errors++;
      $display("FAIL estop_clear: aborted=%b done=%b steps_done=%0d expected 0,1,0", aborted, done, steps_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_move;
    int r = 0, c = 0;
    logic p = 0;
    send_cmd(1, 30, 100);
    while (r < 15 && c < 5000) begin
      @(posedge clk); #1;
      c++;
      if (step && !p) r++;
      p = step;
    end
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if ({step, dir, busy, done, aborted, cmd_ready} !== 6'b000001 || steps_done !== '0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b steps_done=%0d expected 000001,0", {step, dir, busy, done, aborted, cmd_ready}, steps_done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: done=%b busy=%b expected 0,0", done, busy);
    end
    rst = 0;
    build_model(2, 200);
    send_cmd(1, 2, 200);
    collect(DS + 500, 0, 0);
    checks++;
    if (rise_q.size() !== 2 || done_at !== DS + model_sum() || steps_done !== SIZE'(2)) begin
      errors++;
      $display("FAIL reset_resume: pulses=%0d done_at=%0d steps_done=%0d expected 2,%0d,2", rise_q.size(), done_at, steps_done, DS + model_sum());
    end
  endtask

  task automatic test_busy_ignore;
    build_model(3, 200);
    send_cmd(1, 3, 200);
    collect(DS + 700, 0, 1);
    checks++;
    if (ready_busy !== 0 || dir_bad !== 0) begin
      errors++;
      $display("FAIL busy_ready: ready_while_busy=%0d dir_changes=%0d expected 0,0", ready_busy, dir_bad);
    end
    checks++;
    if (rise_q.size() !== 3 || steps_done !== SIZE'(3) || done_at !== DS + model_sum()) begin
      errors++;
      $display("FAIL busy_ignore: pulses=%0d steps_done=%0d done_at=%0d expected 3,3,%0d", rise_q.size(), steps_done, done_at, DS + model_sum());
    end
  endtask

  initial begin
    test_reset();
    test_profiles();
    test_stop();
    test_estop();
    test_reset_mid_move();
    test_busy_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
